// File: rtl/fifo_uart_tx.sv
// UART transmitter draining an async-FIFO read port: one rinc pop per word, 8N1 frames LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx #(
  parameter int DSIZE    = 8,
  parameter int BAUD_DIV = 104
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             tx_en,
  output logic             tx,
  output logic             busy
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DSIZE + 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [DSIZE-1:0] sh_q, sh_d;
  logic             rinc_q, rinc_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             baud_last, load_ok, load;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign baud_last = (baud_q == BW'(BAUD_DIV - 1));
  assign load_ok   = tx_en && !rempty;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    load    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE:  load = load_ok;
      START: if (baud_last) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (baud_last) begin
        sh_d = sh_q >> 1;
        if (bit_q == CW'(DSIZE - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (baud_last) state_d = STOP;
`endif
      STOP: if (baud_last) begin
        if (load_ok) load = 1'b1;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Load wins over everything: capture head word, pop it, start bit next.
    if (load) begin
      state_d = START;
      sh_d    = rdata;
      baud_d  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = ^rdata;
`endif
    end
    rinc_d = load;

    // tx is decoded from the next state so the line level is itself a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rinc_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rinc_q  <= rinc_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rinc = rinc_q;
  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Single-clock UART transmitter that drains the read port of the team's async FIFO and serialises each word onto a TX line. It sits in the read-clock domain. It consumes `rdata`/`rempty` directly, issues one `rinc` pop per word, and emits standard 8N1 frames (optionally 8E1), sent LSB first, with gapless back-to-back transmission while data is available.

## Interface

Parameters:
- `DSIZE`, default 8: data bits per frame; must match the FIFO's `DSIZE`.
- `BAUD_DIV`, default 104: `rclk` cycles per bit; legal range is 2 or more.

Ports (one clock; reset is asynchronous and active-low):
- `rclk`  input  1: clock; the FIFO read-side clock.
- `rrst_n`  input  1: asynchronous active-low reset.
- `rdata`  input  DSIZE: FIFO head word; valid whenever `rempty` = 0.
- `rempty`  input  1: FIFO empty flag, registered in the `rclk` domain.
- `rinc`  output  1: pop strobe, registered; exactly one cycle high per word consumed.
- `tx_en`  input  1: permits new frames to start; a frame already in progress always completes.
- `tx`  output  1: serial line; idle level is high.
- `busy`  output  1: registered; high whenever the state is not IDLE.

## Operation

- States: IDLE, START, DATA, (PARITY), STOP.
- Load condition: `tx_en` = 1 and `rempty` = 0, sampled in IDLE or on the final cycle of STOP.
- On load:
  - `rdata` is captured into the shift register.
  - The next state is START.
  - `tx` <= 0.
  - `rinc` <= 1 for one cycle, so the FIFO pops on the following edge.
- Sequence after START:
  - START lasts `BAUD_DIV` cycles, then the state moves to DATA.
  - DATA shifts out `DSIZE` bits LSB first, each for `BAUD_DIV` cycles.
  - DATA then moves to PARITY if it is compiled in, otherwise to STOP.
  - STOP holds `tx` = 1 for `BAUD_DIV` cycles.
- End of STOP: the state reloads if the load condition holds; otherwise it goes to IDLE.
- Counters:
  - The baud counter is `$clog2(BAUD_DIV)` bits; it counts 0 to `BAUD_DIV`-1 and wraps at each bit boundary.
  - The bit counter is `$clog2(DSIZE+1)` bits and is cleared on entry to DATA.
- `rempty` is ignored outside the load condition. A pop issued at load is always reflected in `rempty` before the next load check.
- `tx_en` falling mid-frame has no effect on the current frame; no further load occurs.
- `rdata` is not sampled except at load; changes at other times are ignored.

## Timing

- Reset values (asynchronous): state IDLE, `tx` = 1, `rinc` = 0, `busy` = 0, counters 0.
- Load latency: if `rempty` falls, or `tx_en` rises, before edge N, then after edge N `tx` = 0, `busy` = 1 and `rinc` = 1. `rinc` is 0 again after edge N+1.
- Frame length is (2 + `DSIZE`) × `BAUD_DIV` cycles, or (3 + `DSIZE`) × `BAUD_DIV` with parity.
- Back-to-back: the start bit of the next frame follows the last stop-bit cycle with zero idle cycles.
- Reset mid-frame: `tx` returns high immediately and the frame is aborted. The word already popped is lost; there is no re-pop.
- `tx` and `busy` are driven straight from flops, with no combinational path from inputs.

## Configuration

- `FIFO_UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits even parity, i.e. the XOR of all `DSIZE` data bits, for `BAUD_DIV` cycles.
- Not defined:
  - There is no PARITY state and no parity logic.
  - DATA proceeds directly to STOP.

## Test plan

- Reset with `rempty` = 1 and `tx_en` = 1, held for 200 cycles: `tx` = 1, `rinc` = 0 and `busy` = 0 throughout.
- `BAUD_DIV` = 4, one word 0xA5:
  - Exactly one `rinc` pulse, on the cycle after load.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles.
  - `busy` high for 40 cycles, then IDLE.
- `BAUD_DIV` = 4, words 0x00, 0xFF, 0x55 queued:
  - Exactly 3 `rinc` pulses.
  - 120 contiguous frame cycles with no idle-high gap between stop and start.
  - Frames decode correctly and `rempty` = 1 at the end.
- `tx_en` = 0 with a non-empty FIFO: no `rinc` and `tx` stays 1. Raise `tx_en` and drop it 5 cycles into the frame: that frame completes and no second frame starts.
- Assert `rrst_n` = 0 during data bit 3: `tx` = 1 and `busy` = 0 immediately. After release, the next FIFO word is sent intact.
- With `FIFO_UART_TX_PARITY_EN` and `BAUD_DIV` = 4, word 0x07: parity bit = 1 and the frame is 44 cycles. Word 0x03: parity bit = 0.
